fwd_hazard_unit: RTL

//  Operand-forwarding and load-use hazard controller for the EX-stage operand muxes (mux4_to_1 x2).

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_match.sv | 20 ++
 rtl/fwd_hazard_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit:
// operand-mux select codes and the pipe-entry record.
package fwd_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             is_load;
  } pipe_ent_t;

endpackage

// File: rtl/fwd_match.sv
// Producer/consumer match for one pipe entry and one source.
// Ports: ent_i entry, src_i source reg, use_i source read, hit_o.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int ZERO_REG = 0
) (
  input  pipe_ent_t        ent_i,
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  output logic             hit_o
);

  localparam logic [REG_W-1:0] ZR = ZERO_REG[REG_W-1:0];

  // The zero register is hard-wired, so it is never a forwarding target.
  assign hit_o = use_i & ent_i.valid & ent_i.wen
               & (ent_i.rd == src_i) & (src_i != ZR);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall at the ID/EX boundary.
// Ports: ID operand/dest info and flush in; registered A/B selects and stall out.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_BITS = REG_W,
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                id_use_imm,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_wen,
  input  logic                id_is_load,
  input  logic                flush,
  output logic                a_s1,
  output logic                a_s0,
  output logic                b_s1,
  output logic                b_s0,
  output logic                stall
);

  pipe_ent_t  ex_q, ex_d, mem_q;
  logic [1:0] a_sel_q, a_sel_d;
  logic [1:0] b_sel_q, b_sel_d;

  logic a_ex, a_mem, b_ex, b_mem;
  logic b_use;
  logic adv;

  // An immediate operand B never reads rt, so it cannot hazard.
  assign b_use = id_use_rt & ~id_use_imm;

  fwd_match #(.ZERO_REG(ZERO_REG)) u_a_ex (
    .ent_i (ex_q),
    .src_i (id_rs),
    .use_i (id_use_rs),
    .hit_o (a_ex)
  );

  fwd_match #(.ZERO_REG(ZERO_REG)) u_a_mem (
    .ent_i (mem_q),
    .src_i (id_rs),
    .use_i (id_use_rs),
    .hit_o (a_mem)
  );

  fwd_match #(.ZERO_REG(ZERO_REG)) u_b_ex (
    .ent_i (ex_q),
    .src_i (id_rt),
    .use_i (b_use),
    .hit_o (b_ex)
  );

  fwd_match #(.ZERO_REG(ZERO_REG)) u_b_mem (
    .ent_i (mem_q),
    .src_i (id_rt),
    .use_i (b_use),
    .hit_o (b_mem)
  );

  // A load in EX has no result yet; hold ID one cycle.
  // Flush discards ID, so it suppresses the stall.
  assign stall = id_valid & ~flush & ex_q.is_load
               & (a_ex | b_ex);

  assign adv = id_valid & ~flush & ~stall;

  always_comb begin
    ex_d    = '0;
    a_sel_d = SEL_REG;
    b_sel_d = SEL_REG;
    if (adv) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_rd;
      ex_d.wen     = id_wen;
      ex_d.is_load = id_is_load;
      // Youngest producer wins.
      if (a_ex)       a_sel_d = SEL_EXMEM;
      else if (a_mem) a_sel_d = SEL_MEMWB;
      if (id_use_imm) b_sel_d = SEL_IMM;
      else if (b_ex)  b_sel_d = SEL_EXMEM;
      else if (b_mem) b_sel_d = SEL_MEMWB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      a_sel_q <= SEL_REG;
      b_sel_q <= SEL_REG;
    end else begin
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
    end
  end

  assign {a_s1, a_s0} = a_sel_q;
  assign {b_s1, b_s0} = b_sel_q;

endmodule
